gcd_lcm_unit: RTL and testbench

//  Multi-cycle GCD/LCM coprocessor driven by the main decoder's Start and ALU3SrcA controls.

---
 rtl/gcd_lcm_pkg.sv | 14 +
 rtl/gcd_lcm_if.sv | 21 ++
 rtl/gcd_lcm_seq_divider.sv | 55 +++++
 rtl/gcd_lcm_unit.sv | 122 ++++++++++++
 tb/tb_gcd_lcm_unit.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/gcd_lcm_pkg.sv
// Shared types and opcode constants for the GCD/LCM coprocessor and the main decoder.
package gcd_lcm_pkg;

  typedef enum logic [2:0] {IDLE, GCD, DIV, MUL, DONE} state_t;
  typedef enum logic {OP_GCD = 1'b0, OP_LCM = 1'b1} op_t;

  localparam logic [6:0] FUNCT7_GCD = 7'b0000000;
  localparam logic [6:0] FUNCT7_LCM = 7'b0000001;

  function automatic op_t decode_op(input logic is_lcm);
    return is_lcm ? OP_LCM : OP_GCD;
  endfunction

endpackage

// File: rtl/gcd_lcm_if.sv
// Core <-> GCD/LCM unit handshake. Optional ovf flag when GCD_LCM_OVF_EN is defined.
interface gcd_lcm_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_lcm;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;
`ifdef GCD_LCM_OVF_EN
  logic             ovf;

  modport master (output start, is_lcm, a, b, input stall, done, result, ovf);
  modport slave  (input start, is_lcm, a, b, output stall, done, result, ovf);
`else
  modport master (output start, is_lcm, a, b, input stall, done, result);
  modport slave  (input start, is_lcm, a, b, output stall, done, result);
`endif
endinterface

// File: rtl/gcd_lcm_seq_divider.sv
// Restoring divider: one quotient bit per cycle, exactly WIDTH busy cycles after start.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] STEPS = CW'(WIDTH);

  logic [WIDTH-1:0] quo, rem, dsr;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             fits;

  assign trial = {rem, quo[WIDTH-1]};
  assign fits  = trial >= {1'b0, dsr};
  // when fits, trial - dsr < dsr, so the low WIDTH bits are exact
  assign diff  = trial[WIDTH-1:0] - dsr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      quo  <= '0;
      rem  <= '0;
      dsr  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      quo  <= dividend;
      rem  <= '0;
      dsr  <= divisor;
      cnt  <= STEPS;
      busy <= 1'b1;
    end else if (busy) begin
      rem <= fits ? diff : trial[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], fits};
      cnt <= cnt - 1'b1;
      if (cnt == 1) busy <= 1'b0;
    end
  end

  // done marks the final step; quotient/remainder are valid from the next cycle
  assign done      = busy && (cnt == 1);
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/gcd_lcm_unit.sv
// Multi-cycle GCD (subtractive Euclid) / LCM ((a/g)*b) coprocessor that stalls the core.
// GCD_LCM_OVF_EN adds an ovf flag reporting lcm truncation on the done cycle.
module gcd_lcm_unit
  import gcd_lcm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset_n,
  gcd_lcm_if.slave  bus
);
  state_t           state, state_n;
  op_t              op_r;
  logic [WIDTH-1:0] a_r, b_r, x, y, result_r;
  logic             gcd_hit, zero_op, div_start, div_done;
  logic [WIDTH-1:0] g, div_quo, div_rem_unused;
  logic             div_busy_unused;

  assign gcd_hit = (x == y) || (x == '0) || (y == '0);
  assign g       = x | y;
  assign zero_op = (a_r == '0) || (b_r == '0);

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_start),
    .dividend  (a_r),
    .divisor   (g),
    .busy      (div_busy_unused),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem_unused)
  );

`ifdef GCD_LCM_OVF_EN
  logic [2*WIDTH-1:0] prod;
  logic               ovf_r;
  assign prod    = (2*WIDTH)'(div_quo) * (2*WIDTH)'(b_r);
  assign bus.ovf = (state == DONE) && ovf_r;
`else
  logic [WIDTH-1:0] prod;
  assign prod = div_quo * b_r;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    div_start = 1'b0;
    case (state)
      IDLE: if (bus.start) state_n = GCD;
      GCD: begin
        if (gcd_hit) begin
          if (op_r == OP_GCD || zero_op) begin
            state_n = DONE;
          end else begin
            state_n   = DIV;
            div_start = 1'b1;
          end
        end
      end
      DIV:     if (div_done) state_n = MUL;
      MUL:     state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_r     <= OP_GCD;
      a_r      <= '0;
      b_r      <= '0;
      x        <= '0;
      y        <= '0;
      result_r <= '0;
`ifdef GCD_LCM_OVF_EN
      ovf_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_r  <= decode_op(bus.is_lcm);
            a_r   <= bus.a;
            b_r   <= bus.b;
            x     <= bus.a;
            y     <= bus.b;
`ifdef GCD_LCM_OVF_EN
            ovf_r <= 1'b0;
`endif
          end
        end
        GCD: begin
          if (gcd_hit) begin
            if (op_r == OP_GCD) result_r <= g;
            else if (zero_op)   result_r <= '0;
          end else if (x > y) begin
            x <= x - y;
          end else begin
            y <= y - x;
          end
        end
        MUL: begin
          result_r <= prod[WIDTH-1:0];
`ifdef GCD_LCM_OVF_EN
          ovf_r    <= |prod[2*WIDTH-1:WIDTH];
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.done   = (state == DONE);
  assign bus.stall  = bus.start && !bus.done;
  assign bus.result = result_r;

endmodule

// File: tb/tb_gcd_lcm_unit.sv
// Scoreboard bench for gcd_lcm_unit: directed corner cases plus randomized ops vs. a math model.
module tb_gcd_lcm_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  gcd_lcm_if #(.WIDTH(W)) bus ();
  gcd_lcm_unit #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           lat;
    int           issue;
    string        name;
  } exp_t;

  exp_t sbq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p, q, t;
    p = a; q = b;
    while (q != 0) begin
      t = p % q; p = q; q = t;
    end
    return p;
  endfunction

  // subtraction count = sum of Euclid quotients, minus the final step that lands on x==y
  function automatic int ref_nsub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p, q, t;
    longint s;
    if (a == 0 || b == 0) return 0;
    p = (a > b) ? a : b;
    q = (a > b) ? b : a;
    s = 0;
    while (q != 0) begin
      s += longint'(p / q);
      t = p % q; p = q; q = t;
    end
    return int'(s - 1);
  endfunction

  function automatic int ref_lat(input logic lcm, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = ref_nsub(a, b) + 2;
    if (lcm && a != 0 && b != 0) n += W + 1;
    return n;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && bus.done === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL spurious_done actual=done_at_cycle_%0d required=no_done", cyc);
      end else begin
        e = sbq.pop_front();
        check({e.name, "_result"}, 64'(bus.result), 64'(e.res));
        check({e.name, "_latency"}, 64'(cyc - e.issue), 64'(e.lat));
`ifdef GCD_LCM_OVF_EN
        check({e.name, "_ovf"}, 64'(bus.ovf), 64'(e.ovf));
`endif
      end
    end
  end

`ifdef GCD_LCM_OVF_EN
  int ovf_stray = 0;
  always @(negedge clk) if (bus.done !== 1'b1 && bus.ovf !== 1'b0) ovf_stray++;
`endif

  task automatic run_op(input string name, input logic lcm, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit wiggle, input bit hold, input int gap);
    exp_t e;
    logic [W-1:0] g;
    logic [63:0] p;
    bit stall_ok;
    g = ref_gcd(a, b);
    e.lat = ref_lat(lcm, a, b);
    e.name = name;
    e.ovf = 1'b0;
    if (!lcm) e.res = g;
    else if (a == 0 || b == 0) e.res = '0;
    else begin
      p = {32'd0, a / g} * {32'd0, b};
      e.res = p[W-1:0];
      e.ovf = |p[63:W];
    end
    @(negedge clk);
    bus.start = 1'b1; bus.is_lcm = lcm; bus.a = a; bus.b = b;
    e.issue = cyc;
    sbq.push_back(e);
    stall_ok = 1'b1;
    for (int n = 1; n <= e.lat + 1; n++) begin
      @(negedge clk);
      if (bus.stall !== (bus.start && n != e.lat)) stall_ok = 1'b0;
      if (!hold) bus.start = 1'b0;
      if (wiggle) begin
        bus.a = $urandom; bus.b = $urandom; bus.is_lcm = 1'($urandom);
      end
    end
    bus.start = 1'b0;
    check({name, "_stall"}, 64'(stall_ok), 64'd1);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bus.start = 1'b0; bus.is_lcm = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_result", 64'(bus.result), 64'd0);
    check("reset_stall", 64'(bus.stall), 64'd0);
    reset_n = 1'b1;

    run_op("gcd_12_18", 1'b0, 32'd12, 32'd18, 1'b0, 1'b1, 1);
    run_op("lcm_12_18", 1'b1, 32'd12, 32'd18, 1'b0, 1'b1, 40);
    run_op("gcd_0_0",   1'b0, 32'd0,  32'd0,  1'b0, 1'b1, 0);
    run_op("gcd_0_7",   1'b0, 32'd0,  32'd7,  1'b0, 1'b1, 0);
    run_op("gcd_7_0",   1'b0, 32'd7,  32'd0,  1'b0, 1'b1, 0);
    run_op("lcm_0_5",   1'b1, 32'd0,  32'd5,  1'b0, 1'b1, 0);
    run_op("lcm_5_0",   1'b1, 32'd5,  32'd0,  1'b0, 1'b1, 0);
    run_op("lcm_trunc", 1'b1, 32'hFFFF_0000, 32'h0007_0000, 1'b0, 1'b1, 2);

    // abort an lcm mid-divide
    @(negedge clk);
    bus.start = 1'b1; bus.is_lcm = 1'b1; bus.a = 32'd12; bus.b = 32'd18;
    repeat (10) @(negedge clk);
    reset_n = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_result", 64'(bus.result), 64'd0);
    check("abort_stall", 64'(bus.stall), 64'd0);
    reset_n = 1'b1;
    run_op("gcd_9_6_after_abort", 1'b0, 32'd9, 32'd6, 1'b0, 1'b1, 0);

    run_op("gcd_35_14_wiggle", 1'b0, 32'd35, 32'd14, 1'b1, 1'b1, 0);
    run_op("lcm_21_6_nohold",  1'b1, 32'd21, 32'd6,  1'b1, 1'b0, 1);

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      run_op($sformatf("rnd%0d", i), 1'($urandom), ra, rb, 1'($urandom), 1'($urandom),
             $urandom_range(0, 2));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
`ifdef GCD_LCM_OVF_EN
    check("ovf_outside_done", 64'(ovf_stray), 64'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
